// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with first-word-fall-through read port and sticky overrun flag
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] WR_DI,
    input  logic                 WR_DRDY,
    output logic [DATA_BITS-1:0] RD_DO,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic [ADDR_W:0]      COUNT,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 OVERFLOW,
    input  logic                 OVF_CLR
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 drop;

    assign FULL     = (COUNT == DEPTH_C);
    assign EMPTY    = (COUNT == '0);
    assign RD_VALID = !EMPTY;
    assign RD_DO    = RD_VALID ? mem[rd_ptr] : '0;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a byte.
    assign pop  = RD_VALID && RD_READY;
    assign push = WR_DRDY && (!FULL || pop);
    assign drop = WR_DRDY && FULL && !pop;

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem[wr_ptr] <= WR_DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                COUNT <= COUNT + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                COUNT <= COUNT - (ADDR_W + 1)'(1);
            end
            // Set wins over clear so a drop is never hidden by a concurrent clear.
            if (drop) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and random scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] WR_DI;
    logic       WR_DRDY;
    logic [7:0] RD_DO;
    logic       RD_VALID;
    logic       RD_READY;
    logic [4:0] COUNT;
    logic       FULL;
    logic       EMPTY;
    logic       OVERFLOW;
    logic       OVF_CLR;

    int         total  = 0;
    int         passed = 0;
    logic [7:0] sb [$];
    logic       m_ovf = 1'b0;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_DI    (WR_DI),
        .WR_DRDY  (WR_DRDY),
        .RD_DO    (RD_DO),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .OVERFLOW (OVERFLOW),
        .OVF_CLR  (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state();
        chk("count", 32'(COUNT), 32'(sb.size()));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        chk("full", 32'(FULL), 32'(sb.size() == 16));
        chk("empty", 32'(EMPTY), 32'(sb.size() == 0));
    endtask

    // One clock: drive inputs, check the read port against the model, update model, check state.
    task automatic cycle(input logic drdy, input logic [7:0] di, input logic rdy, input logic clr);
        logic pop;
        logic drop;
        WR_DRDY  = drdy;
        WR_DI    = di;
        RD_READY = rdy;
        OVF_CLR  = clr;
        chk("rd_valid", 32'(RD_VALID), 32'(sb.size() != 0));
        if (sb.size() != 0) chk("rd_do", 32'(RD_DO), 32'(sb[0]));
        else chk("rd_do_zero", 32'(RD_DO), 32'h0);
        pop  = (sb.size() != 0) && rdy;
        drop = drdy && (sb.size() == 16) && !pop;
        if (pop) void'(sb.pop_front());
        if (drdy && !drop) sb.push_back(di);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        WR_DRDY  = 1'b0;
        RD_READY = 1'b0;
        OVF_CLR  = 1'b0;
        chk_state();
    endtask

    task automatic do_reset(input logic drdy, input logic rdy);
        RST      = 1'b1;
        WR_DRDY  = drdy;
        WR_DI    = 8'hC3;
        RD_READY = rdy;
        OVF_CLR  = 1'b0;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        WR_DRDY  = 1'b0;
        RD_READY = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        chk_state();
        chk("reset_rd_do", 32'(RD_DO), 32'h0);
        chk("reset_rd_valid", 32'(RD_VALID), 32'h0);
    endtask

    initial begin
        RST = 1'b1; WR_DI = '0; WR_DRDY = 1'b0; RD_READY = 1'b0; OVF_CLR = 1'b0;
        @(posedge CLK);
        #1;
        do_reset(1'b0, 1'b0);

        // Three spaced pushes, then read out with ready held high.
        cycle(1, 8'h41, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h62, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h33, 0, 0);
        chk("t1_count", 32'(COUNT), 32'd3);
        chk("t1_head", 32'(RD_DO), 32'h41);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        chk("t1_empty", 32'(EMPTY), 32'd1);
        chk("t1_rd_do", 32'(RD_DO), 32'h0);

        // Fill, overflow drop, drain, clear.
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
        chk("t2_full", 32'(FULL), 32'd1);
        cycle(1, 8'hAA, 0, 0);
        chk("t2_ovf_set", 32'(OVERFLOW), 32'd1);
        chk("t2_count_held", 32'(COUNT), 32'd16);
        for (int i = 0; i < 17; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
        chk("t2_ovf_clr", 32'(OVERFLOW), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'h55, 1, 0);
        chk("t3_count", 32'(COUNT), 32'd16);
        chk("t3_ovf", 32'(OVERFLOW), 32'd0);
        for (int i = 0; i < 17; i++) cycle(0, 8'h00, 1, 0);

        // Random traffic across many pointer wraps.
        for (int i = 0; i < 120; i++) begin
            cycle((i % 3) == 0, 8'($urandom), 1'($urandom % 2), 0);
            chk("t4_count_bound", 32'(COUNT <= 5'd16), 32'd1);
        end
        for (int i = 0; i < 18; i++) cycle(0, 8'h00, 1, 0);
        chk("t4_no_ovf", 32'(OVERFLOW), 32'd0);

        // Single push latency, then drop coinciding with clear.
        chk("t5_pre_valid", 32'(RD_VALID), 32'd0);
        cycle(1, 8'h9C, 0, 0);
        chk("t5_valid_rise", 32'(RD_VALID), 32'd1);
        for (int i = 0; i < 15; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        cycle(1, 8'hEE, 0, 1);
        chk("t5_set_wins", 32'(OVERFLOW), 32'd1);

        // Reset with contents, push and pop pending.
        for (int i = 0; i < 9; i++) cycle(0, 8'h00, 1, 0);
        chk("t6_count7", 32'(COUNT), 32'd7);
        do_reset(1'b1, 1'b1);
        cycle(0, 8'h00, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between `uart_rx` and the application logic, such as LED decode or a command parser. It captures every byte that `uart_rx` presents with its one-cycle `RX_DRDY` strobe, stores it in a circular buffer, and presents the bytes in order on a first-word-fall-through valid/ready read port. Overrun is detected and latched so that software or a bench can see that bytes were lost.

## Interface
Parameters:
- `DATA_BITS`, default 8: byte width. Matches `uart_rx` `DATA_BITS`.
- `DEPTH`, default 16: number of entries. Must be a power of two, 2 or more.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `CLK` in, 1: system clock. Same clock as `uart_rx` and `baud_generator`.
- `RST` in, 1: reset. **One clock; reset is synchronous and active-high.**
- `WR_DI` in, `DATA_BITS`: write data. Connects to `uart_rx` `RX_DO`.
- `WR_DRDY` in, 1: write strobe, one cycle per byte. Connects to `uart_rx` `RX_DRDY`.
- `RD_DO` out, `DATA_BITS`: head-of-queue byte.
- `RD_VALID` out, 1: `RD_DO` holds a valid byte.
- `RD_READY` in, 1: consumer accepts the head byte.
- `COUNT` out, `ADDR_W+1`: number of stored entries, 0..`DEPTH`.
- `FULL` out, 1: `COUNT == DEPTH`.
- `EMPTY` out, 1: `COUNT == 0`.
- `OVERFLOW` out, 1: sticky flag; at least one byte was dropped.
- `OVF_CLR` in, 1: clears `OVERFLOW`.

## Operation
- Storage: `DEPTH` x `DATA_BITS` register array. The array is not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each `ADDR_W` bits, wrap modulo `DEPTH`. The occupancy counter `COUNT` is explicit.
- Push condition: `WR_DRDY && (!FULL || pop)`. A push writes `WR_DI` at `wr_ptr`, then increments `wr_ptr`.
- Pop condition: `pop = RD_VALID && RD_READY`. A pop increments `rd_ptr`.
- `COUNT` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs:
  - `RD_VALID = !EMPTY`.
  - `RD_DO = mem[rd_ptr]` when `RD_VALID`, else all zeros.
  - `FULL`, `EMPTY`, `RD_VALID` and `RD_DO` are combinational from registered state.
- Drop: `WR_DRDY && FULL && !pop` discards the byte. State is unchanged except `OVERFLOW`, which is set to 1.
- `OVERFLOW`:
  - Set on a drop.
  - Cleared on `OVF_CLR` when no drop occurs in the same cycle.
  - A simultaneous drop and `OVF_CLR` leaves it at 1 (set wins).
- Simultaneous push and pop when full: both are performed. The write goes to the slot being vacated (`wr_ptr == rd_ptr`). `COUNT` stays `DEPTH` and there is no overflow.
- Push when empty: no simultaneous pop is possible, because `RD_VALID` is 0.
- Read order is strictly FIFO. No byte is duplicated or reordered, including across pointer wrap.

## Timing
- Reset, sampled at a `CLK` rising edge with `RST=1`:
  - `wr_ptr=0`, `rd_ptr=0`, `COUNT=0`, `OVERFLOW=0`.
  - Therefore `EMPTY=1`, `FULL=0`, `RD_VALID=0`, `RD_DO=0`.
  - `RST` dominates a simultaneous push, pop or `OVF_CLR`.
  - Reset mid-stream discards all contents.
- Write latency: a `WR_DRDY` sampled at edge N makes the byte visible on `RD_DO`/`RD_VALID` after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Pop: takes effect at the edge where `RD_VALID && RD_READY`. The next byte, or `RD_VALID=0`, appears in the following cycle.
- `RD_READY` may be held high continuously, giving one byte per cycle. It may also toggle arbitrarily.
- `RD_DO` is stable while `RD_VALID=1 && RD_READY=0`, even if pushes occur.
- `WR_DRDY` may be asserted on consecutive cycles. Each asserted cycle is one byte; no handshake back to `uart_rx` exists.
- `COUNT` and `OVERFLOW` are registered. Each reflects the cycle's events one cycle after the edge.

## Test plan
- Reset, then push 0x41, 0x62, 0x33 on three non-consecutive `WR_DRDY` pulses, with `RD_READY=0` -> `COUNT=3`, `RD_DO=0x41`, `RD_VALID=1`. Then raise `RD_READY` -> `RD_DO` shows 0x41, 0x62, 0x33 on successive cycles, then `EMPTY=1`, `RD_DO=0`.
- Push 16 bytes 0x00..0x0F -> `FULL=1`, `COUNT=16`. Push 0xAA -> dropped, `OVERFLOW=1`. Drain -> exactly 0x00..0x0F. Pulse `OVF_CLR` -> `OVERFLOW=0`.
- With FIFO full, assert `WR_DRDY` with 0x55 together with a pop -> `COUNT` stays 16, `OVERFLOW` stays 0. Drain -> 0x01..0x0F, then 0x55.
- Continuous wrap: 40 random bytes pushed every 3 cycles, `RD_READY` random 50%, compared against a queue model -> zero mismatches, no overflow, `COUNT` never above 16.
- Single push into empty FIFO -> `RD_VALID` rises exactly one cycle after the `WR_DRDY` edge. Drop and `OVF_CLR` in the same cycle -> `OVERFLOW=1`.
- Assert `RST` for one cycle with `COUNT=7`, a push and a pop all pending -> next cycle `COUNT=0`, `EMPTY=1`, `OVERFLOW=0`, `RD_DO=0`.
- Full system: `uart_rx` plus FIFO, receiving 16 random serial bytes at 115200 baud with a 100 MHz `CLK` -> the FIFO read-out matches the sent sequence.
